gate_netlist_eval: RTL and testbench

//  Programmable, sequential evaluator for combinational gate models in the simulator gate library.
//  A gate list is loaded at run time into an internal program RAM. The list is topologically ordered.
//  The block evaluates one gate per clock over a net store and latches selected nets onto the outputs.
//  It replaces fixed-function generated netlists: one instance evaluates any model up to its limits.

---
 rtl/gate_netlist_pkg.sv | 45 ++++
 rtl/gate_eval_alu.sv | 35 +++
 rtl/gate_netlist_eval.sv | 122 ++++++++++++
 tb/tb_gate_netlist_eval.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_netlist_pkg.sv
// Shared types and constants for the programmable gate-netlist evaluator.
package gate_netlist_pkg;

  localparam int unsigned NUM_IN_DEF    = 17;
  localparam int unsigned NUM_OUT_DEF   = 10;
  localparam int unsigned NUM_NETS_DEF  = 512;
  localparam int unsigned NUM_GATES_DEF = 320;
  localparam int unsigned MAX_FANIN     = 4;

  localparam int unsigned NET_W  = $clog2(NUM_NETS_DEF);
  localparam int unsigned OP_W   = 3;
  localparam int unsigned NFAN_W = 2;
  localparam int unsigned GATE_W = OP_W + NFAN_W + 5 * NET_W;

  localparam logic [NET_W-1:0] NET_CONST0 = '0;

  typedef enum logic [OP_W-1:0] {
    OP_BUF  = 3'd0,
    OP_NOT  = 3'd1,
    OP_AND  = 3'd2,
    OP_NAND = 3'd3,
    OP_OR   = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [NFAN_W-1:0] nfan_m1;
    logic [NET_W-1:0]  dst;
    logic [NET_W-1:0]  src0;
    logic [NET_W-1:0]  src1;
    logic [NET_W-1:0]  src2;
    logic [NET_W-1:0]  src3;
  } gate_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_OUT
  } state_e;

endpackage

// File: rtl/gate_eval_alu.sv
// Single-gate evaluator: opcode, fan-in and source bits in, one result bit out.
module gate_eval_alu
  import gate_netlist_pkg::*;
(
  input  op_e                  op,
  input  logic [NFAN_W-1:0]    nfan_m1,
  input  logic [MAX_FANIN-1:0] src,
  output logic                 res
);

  logic [MAX_FANIN-1:0] mask;
  logic [MAX_FANIN-1:0] used;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_FANIN; i++) begin
      mask[i] = (i <= 32'(nfan_m1));
    end
    used = src & mask;
    res  = 1'b0;
    // Unused inputs are forced to the identity value of each reduction.
    case (op)
      OP_BUF:  res = src[0];
      OP_NOT:  res = ~src[0];
      OP_AND:  res = &(src | ~mask);
      OP_NAND: res = ~&(src | ~mask);
      OP_OR:   res = |used;
      OP_NOR:  res = ~|used;
      OP_XOR:  res = ^used;
      OP_XNOR: res = ~^used;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_netlist_eval.sv
// Sequential evaluator: runs a loaded, topologically ordered gate list one gate per clock.
module gate_netlist_eval
  import gate_netlist_pkg::*;
#(
  parameter int unsigned NUM_IN    = NUM_IN_DEF,
  parameter int unsigned NUM_OUT   = NUM_OUT_DEF,
  parameter int unsigned NUM_NETS  = NUM_NETS_DEF,
  parameter int unsigned NUM_GATES = NUM_GATES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         prog_we,
  input  logic [$clog2(NUM_GATES)-1:0] prog_addr,
  input  logic [3+2+5*$clog2(NUM_NETS)-1:0] prog_data,
  input  logic [$clog2(NUM_GATES):0]   gate_count,
  input  logic                         omap_we,
  input  logic [$clog2(NUM_OUT)-1:0]   omap_idx,
  input  logic [$clog2(NUM_NETS)-1:0]  omap_net,
  input  logic [NUM_IN-1:0]            in_vec,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_OUT-1:0]           out_vec,
  output logic                         err
);

  localparam int unsigned NW = $clog2(NUM_NETS);
  localparam int unsigned GW = $clog2(NUM_GATES);
  localparam int unsigned OW = $clog2(NUM_OUT);
  localparam int unsigned CW = GW + 1;

  state_e state, state_nxt;

  logic [GATE_W-1:0]   prog_ram [NUM_GATES];
  logic [NW-1:0]       omap     [NUM_OUT];
  logic [NUM_NETS-1:0] nets;
  logic [CW-1:0]       count_q;
  logic [GW-1:0]       gp;
  logic [NUM_IN-1:0]   in_q;

  gate_word_t gw;
  logic       alu_res;
  logic       start_ok;
  logic       last_gate;
  logic       idle;

  assign idle      = (state == S_IDLE);
  assign start_ok  = start && idle;
  assign gw        = gate_word_t'(prog_ram[gp]);
  assign last_gate = ({1'b0, gp} == count_q - 1'b1);

  gate_eval_alu u_alu (
    .op      (gw.op),
    .nfan_m1 (gw.nfan_m1),
    .src     ({nets[gw.src3], nets[gw.src2], nets[gw.src1], nets[gw.src0]}),
    .res     (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (count_q == '0) ? S_OUT : S_EVAL;
      S_EVAL: if (last_gate) state_nxt = S_OUT;
      S_OUT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Program RAM and output map are configuration storage and survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && idle && prog_addr < GW'(NUM_GATES)) prog_ram[prog_addr] <= prog_data;
    if (omap_we && idle && omap_idx < OW'(NUM_OUT))    omap[omap_idx]      <= omap_net;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      out_vec <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        busy <= 1'b1;
        in_q <= in_vec;
        if (gate_count > CW'(NUM_GATES)) begin
          count_q <= CW'(NUM_GATES);
          err     <= 1'b1;
        end else begin
          count_q <= gate_count;
          err     <= 1'b0;
        end
      end
      if ((prog_we || omap_we) && !idle) err <= 1'b1;
      case (state)
        S_LOAD: begin
          nets <= NUM_NETS'({in_q, 1'b0});
          gp   <= '0;
        end
        S_EVAL: begin
          gp <= gp + 1'b1;
          // Constant net and primary inputs are read-only.
          if (gw.dst <= NW'(NUM_IN)) err <= 1'b1;
          else                       nets[gw.dst] <= alu_res;
        end
        S_OUT: begin
          for (int unsigned i = 0; i < NUM_OUT; i++) out_vec[i] <= nets[omap[i]];
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_netlist_eval.sv
// Randomized self-checking bench for gate_netlist_eval against a behavioural netlist model.
module tb_gate_netlist_eval;

  logic        clk = 1'b0;
  logic        rst, prog_we, omap_we, start;
  logic [8:0]  prog_addr;
  logic [49:0] prog_data;
  logic [9:0]  gate_count;
  logic [3:0]  omap_idx;
  logic [8:0]  omap_net;
  logic [16:0] in_vec;
  logic        busy, done, err;
  logic [9:0]  out_vec;

  int n_cmp = 0;
  int n_bad = 0;

  int sh_op  [320];
  int sh_nf  [320];
  int sh_dst [320];
  int sh_src [320][4];
  int sh_omap[10];

  gate_netlist_eval #(.NUM_IN(17), .NUM_OUT(10), .NUM_NETS(512), .NUM_GATES(320)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .gate_count(gate_count), .omap_we(omap_we), .omap_idx(omap_idx), .omap_net(omap_net),
    .in_vec(in_vec), .start(start), .busy(busy), .done(done), .out_vec(out_vec), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [49:0] word(int op, int nf, int dst, int s0, int s1, int s2, int s3);
    return {3'(op), 2'(nf), 9'(dst), 9'(s0), 9'(s1), 9'(s2), 9'(s3)};
  endfunction

  task automatic put_gate(int a, int op, int nf, int dst, int s0, int s1, int s2, int s3);
    sh_op[a] = op; sh_nf[a] = nf; sh_dst[a] = dst;
    sh_src[a][0] = s0; sh_src[a][1] = s1; sh_src[a][2] = s2; sh_src[a][3] = s3;
    prog_we = 1'b1; prog_addr = 9'(a); prog_data = word(op, nf, dst, s0, s1, s2, s3);
    tick();
    prog_we = 1'b0;
  endtask

  task automatic put_omap(int i, int net);
    sh_omap[i] = net;
    omap_we = 1'b1; omap_idx = 4'(i); omap_net = 9'(net);
    tick();
    omap_we = 0;
  endtask

  // Reference: walk the gate list in order over an array of net values.
  task automatic model(input int gc, input logic [16:0] inv, output logic [9:0] o, output logic e);
    bit nv[512];
    int n, ones;
    bit r;
    e = 1'b0;
    if (gc > 320) begin gc = 320; e = 1'b1; end
    foreach (nv[k]) nv[k] = 1'b0;
    for (int k = 1; k <= 17; k++) nv[k] = inv[k-1];
    for (int g = 0; g < gc; g++) begin
      n = (sh_op[g] < 2) ? 1 : sh_nf[g] + 1;
      ones = 0;
      for (int j = 0; j < n; j++) ones += int'(nv[sh_src[g][j]]);
      case (sh_op[g])
        0: r = (ones == 1);
        1: r = (ones == 0);
        2: r = (ones == n);
        3: r = (ones != n);
        4: r = (ones > 0);
        5: r = (ones == 0);
        6: r = (ones % 2 == 1);
        default: r = (ones % 2 == 0);
      endcase
      if (sh_dst[g] <= 17) e = 1'b1;
      else nv[sh_dst[g]] = r;
    end
    for (int i = 0; i < 10; i++) o[i] = nv[sh_omap[i]];
  endtask

  task automatic run(input int gc, input logic [16:0] inv, output int lat,
                     output logic [9:0] o, output logic e);
    gate_count = 10'(gc); in_vec = inv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 1000) begin tick(); lat++; end
    o = out_vec; e = err;
  endtask

  task automatic test_reset();
    int dones;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || out_vec !== '0) begin
      n_bad++; $display("FAIL reset_values busy=%b done=%b err=%b out=%h required 0/0/0/000", busy, done, err, out_vec);
    end
    for (int g = 0; g < 20; g++) put_gate(g, 1, 0, 18 + g, 1, 0, 0, 0);
    gate_count = 10'd20; in_vec = 17'h1ffff; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid_eval got %b required 1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_vec !== '0) begin
      n_bad++; $display("FAIL reset_mid_eval busy=%b out=%h required 0/000", busy, out_vec);
    end
    dones = 0;
    repeat (30) begin tick(); if (done) dones++; end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL reset_no_done got %0d pulses required 0", dones); end
  endtask

  task automatic test_single_gate();
    int lat; logic [9:0] o, mo; logic e, me;
    put_gate(0, 3, 1, 18, 2, 3, 0, 0);
    put_omap(0, 18);
    run(1, 17'b011, lat, o, e);
    model(1, 17'b011, mo, me);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL single_latency got %0d required 3", lat); end
    n_cmp++; if (o[0] !== 1'b1) begin n_bad++; $display("FAIL single_nand got %b required 1", o[0]); end
    n_cmp++; if (o !== mo || e !== me) begin n_bad++; $display("FAIL single_model out=%h err=%b required %h/%b", o, e, mo, me); end
  endtask

  task automatic test_chain();
    int lat, bad_lat, bad_out; logic [9:0] o, mo; logic e, me; logic [16:0] inv;
    put_gate(0, 1, 0, 18, 4, 0, 0, 0);
    put_gate(1, 2, 2, 19, 4, 17, 6, 0);
    put_gate(2, 5, 3, 21, 8, 6, 6, 4);
    put_omap(0, 18); put_omap(1, 19); put_omap(2, 21); put_omap(3, 0);
    for (int i = 4; i < 10; i++) put_omap(i, 1 + i);
    bad_lat = 0; bad_out = 0;
    for (int r = 0; r < 1000; r++) begin
      inv = 17'($urandom);
      run(3, inv, lat, o, e);
      model(3, inv, mo, me);
      n_cmp++; if (lat !== 5) begin n_bad++; bad_lat++;
        if (bad_lat < 4) $display("FAIL chain_latency got %0d required 5", lat); end
      n_cmp++; if (o !== mo || e !== me) begin n_bad++; bad_out++;
        if (bad_out < 4) $display("FAIL chain_out in=%h out=%h err=%b required %h/%b", inv, o, e, mo, me); end
    end
  endtask

  task automatic test_zero_gates();
    int lat; logic [9:0] o; logic e;
    put_omap(0, 5);
    run(0, 17'h00010, lat, o, e);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL zero_latency got %0d required 2", lat); end
    n_cmp++; if (o[0] !== 1'b1 || e !== 1'b0) begin n_bad++; $display("FAIL zero_out out0=%b err=%b required 1/0", o[0], e); end
  endtask

  task automatic test_bad_dst();
    int lat; logic [9:0] o; logic e; logic [16:0] inv;
    inv = 17'($urandom);
    put_gate(0, 1, 0, 3, 5, 0, 0, 0);
    put_gate(1, 0, 0, 18, 3, 0, 0, 0);
    put_omap(0, 3); put_omap(1, 18);
    run(2, inv, lat, o, e);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL baddst_done latency %0d required 4", lat); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL baddst_err got %b required 1", e); end
    n_cmp++; if (o[1:0] !== {inv[2], inv[2]}) begin n_bad++; $display("FAIL baddst_net3 got %b required %b", o[1:0], {inv[2], inv[2]}); end
    put_gate(0, 1, 0, 20, 5, 0, 0, 0);
    gate_count = 10'd1; start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL start_clears_err got %b required 0", err); end
    repeat (4) tick();
  endtask

  task automatic test_busy_writes();
    int dones, cyc; logic [9:0] o, mo; logic e, me; logic [16:0] inv;
    inv = 17'($urandom);
    put_gate(0, 1, 0, 30, 1, 0, 0, 0);
    for (int g = 1; g < 20; g++) put_gate(g, 0, 0, 40 + g, 1, 0, 0, 0);
    put_omap(0, 30);
    gate_count = 10'd20; in_vec = inv; start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    prog_we = 1'b1; prog_addr = '0; prog_data = word(0, 0, 30, 1, 0, 0, 0); tick(); prog_we = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL prog_we_busy_err got %b required 1", err); end
    start = 1'b1; tick(); start = 1'b0;
    omap_we = 1'b1; omap_idx = 4'd0; omap_net = 9'd2; tick(); omap_we = 1'b0;
    dones = 0; cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    if (done) dones++;
    o = out_vec; e = err;
    repeat (30) begin tick(); if (done) dones++; end
    model(20, inv, mo, me);
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL busy_start_done_count got %0d required 1", dones); end
    n_cmp++; if (o !== mo || o[0] !== ~inv[0]) begin n_bad++; $display("FAIL busy_ram_unchanged out=%h required %h", o, mo); end
    n_cmp++; if (e !== 1'b1 || me !== 1'b0) begin n_bad++; $display("FAIL busy_err_sticky got %b required 1", e); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [9:0] o, mo; logic e, me; logic [16:0] inv;
    put_omap(0, 25);
    inv = 17'($urandom);
    sh_op[0] = 6; sh_nf[0] = 3; sh_dst[0] = 25;
    sh_src[0][0] = 1; sh_src[0][1] = 2; sh_src[0][2] = 3; sh_src[0][3] = 4;
    prog_we = 1'b1; prog_addr = '0; prog_data = word(6, 3, 25, 1, 2, 3, 4);
    gate_count = 10'd1; in_vec = inv; start = 1'b1;
    tick(); prog_we = 1'b0; start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    n_cmp++; if (lat !== 3 || out_vec[0] !== ^inv[3:0]) begin n_bad++;
      $display("FAIL write_with_start lat=%0d out0=%b required 3/%b", lat, out_vec[0], ^inv[3:0]); end
    for (int r = 0; r < 5; r++) begin
      inv = 17'($urandom);
      run(1, inv, lat, o, e);
      model(1, inv, mo, me);
      n_cmp++; if (lat !== 3 || o !== mo || e !== me) begin n_bad++;
        $display("FAIL back_to_back lat=%0d out=%h err=%b required 3/%h/%b", lat, o, e, mo, me); end
    end
  endtask

  task automatic test_random();
    int lat, gc, nbad; logic [9:0] o, mo; logic e, me; logic [16:0] inv;
    nbad = 0;
    for (int r = 0; r < 40; r++) begin
      gc = $urandom_range(1, 30);
      for (int g = 0; g < gc; g++)
        put_gate(g, $urandom_range(0, 7), $urandom_range(0, 3),
                 ($urandom_range(0, 11) == 0) ? $urandom_range(0, 17) : $urandom_range(18, 60),
                 $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60));
      for (int i = 0; i < 10; i++) put_omap(i, $urandom_range(0, 60));
      inv = 17'($urandom);
      run(gc, inv, lat, o, e);
      model(gc, inv, mo, me);
      n_cmp++; if (lat !== gc + 2 || o !== mo || e !== me) begin n_bad++; nbad++;
        if (nbad < 4) $display("FAIL random gc=%0d lat=%0d out=%h err=%b required %0d/%h/%b", gc, lat, o, e, gc + 2, mo, me); end
    end
  endtask

  task automatic test_clamp();
    int lat; logic [9:0] o, mo; logic e, me; logic [16:0] inv;
    for (int g = 0; g < 320; g++)
      put_gate(g, $urandom_range(0, 7), $urandom_range(0, 3), 18 + (g % 200),
               $urandom_range(0, 217), $urandom_range(0, 217), $urandom_range(0, 217), $urandom_range(0, 217));
    for (int i = 0; i < 10; i++) put_omap(i, 200 + i);
    inv = 17'($urandom);
    run(400, inv, lat, o, e);
    model(400, inv, mo, me);
    n_cmp++; if (lat !== 322) begin n_bad++; $display("FAIL clamp_latency got %0d required 322", lat); end
    n_cmp++; if (o !== mo || e !== me || e !== 1'b1) begin n_bad++; $display("FAIL clamp_out out=%h err=%b required %h/1", o, e, mo); end
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; omap_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_data = '0; gate_count = '0; omap_idx = '0; omap_net = '0; in_vec = '0;
    for (int i = 0; i < 10; i++) sh_omap[i] = 0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) put_omap(i, i + 1);
    test_reset();
    test_single_gate();
    test_chain();
    test_zero_gates();
    test_bad_dst();
    test_busy_writes();
    test_back_to_back();
    test_random();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
